uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core
// UART 8N1 receive engine. The asynchronous rxd line is synchronised and
// edge-detected. Bit timing comes from a counter that restarts on every
// start-bit falling edge, so each bit is sampled in its middle.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line rate in bit/s (CLK_FREQ/BAUD_RATE must be >= 4)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   uart_en    receiver enable; low forces IDLE and drops any frame in flight
//   rxd        serial line, idle high
//   rx_data    last correctly received byte, held between frames
//   rx_valid   one-cycle strobe, rx_data updated this cycle
//   frame_err  one-cycle strobe, stop bit was sampled low
//   rx_busy    high while a frame is being received
module uart_rx_core #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_en,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(BIT_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Stage 0/1: metastability synchroniser. Stage 2: delayed copy for edge
  // detection. All stages reset to the idle-line level so reset release on
  // a high line creates no spurious edge.
  logic [2:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= rxd;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic rxd_sync;
  logic fall_edge;
  assign rxd_sync  = sync_reg[1];
  assign fall_edge = !sync_reg[1] && sync_reg[2];

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic [2:0]    idx_reg,   idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg,  data_next;
  logic          valid_reg, valid_next;
  logic          ferr_reg,  ferr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    if (!uart_en) begin
      // Disabled: abandon any frame silently and ignore the line.
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
      shift_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          idx_next = '0;
          if (fall_edge) state_next = START;
        end

        START: begin
          // Half a bit in: a real start bit is still low, a glitch is not.
          if (cnt_reg == CNT_HALF_LAST) begin
            cnt_next   = '0;
            state_next = rxd_sync ? IDLE : DATA;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end

        DATA: begin
          if (cnt_reg == CNT_BIT_LAST) begin
            cnt_next   = '0;
            shift_next = {rxd_sync, shift_reg[7:1]};  // LSB arrives first
            if (idx_reg == 3'd7) begin
              idx_next   = '0;
              state_next = STOP;
            end else begin
              idx_next = idx_reg + 3'd1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end

        STOP: begin
          // Leave right after the mid-bit sample so a start edge that
          // follows with no idle gap is still seen from IDLE.
          if (cnt_reg == CNT_BIT_LAST) begin
            cnt_next   = '0;
            state_next = IDLE;
            if (rxd_sync) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  assign rx_data   = data_reg;
  assign rx_valid  = valid_reg;
  assign frame_err = ferr_reg;
  assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Directed test of uart_rx_core with BIT_CNT=10, HALF=5. The bench
// schedules, per frame it drives, the cycles where rx_busy must be high and
// the single cycle where rx_valid or frame_err must pulse (with the byte),
// using the frame timing rules. A per-cycle compare process checks all four
// outputs against that schedule. Literal checks pin latency and data.
module tb_uart_rx_core;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT / 2;
  localparam int MAXC      = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_en;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_en  (uart_en),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected-behaviour schedule, indexed by absolute cycle.
  bit         exp_busy  [MAXC];
  bit         exp_valid [MAXC];
  bit         exp_ferr  [MAXC];
  bit         exp_rst   [MAXC];
  logic [7:0] exp_byte  [MAXC];
  logic [7:0] model_data = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int last_valid_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_busy(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) if (c < MAXC) exp_busy[c] = 1'b1;
  endtask

  task automatic compare_cycle();
    int c;
    c = cyc;
    if (c < MAXC) begin
      if (exp_rst[c])   model_data = 8'h00;
      if (exp_valid[c]) model_data = exp_byte[c];
      chk("rx_valid",  {31'd0, rx_valid},  {31'd0, exp_valid[c]});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr[c]});
      chk("rx_busy",   {31'd0, rx_busy},   {31'd0, exp_busy[c]});
      chk("rx_data",   {24'd0, rx_data},   {24'd0, model_data});
    end
    if (rx_valid) begin
      n_valid++;
      last_valid_cyc = c;
    end
    if (frame_err) n_ferr++;
  endtask

  // Drive one frame starting right after the current edge (cycle d). The
  // start edge is seen by the receiver at d+2 (two synchroniser stages), so
  // the receiver's relative cycle r is absolute d+2+r.
  // abort_off / rst_off >= 0 drop uart_en / pulse rst_n at that cycle offset.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int abort_off, input int rst_off);
    int d;
    logic [9:0] bits;
    d    = cyc;
    bits = {stop, data, 1'b0};
    if (abort_off >= 0) begin
      set_busy(d + 3, d + abort_off);
    end else if (rst_off >= 0) begin
      set_busy(d + 3, d + rst_off - 1);
      for (int k = 0; k < 3; k++) exp_rst[d + rst_off + k] = 1'b1;
    end else begin
      set_busy(d + 3, d + 2 + HALF + 9 * BIT);
      if (stop) begin
        exp_valid[d + 3 + HALF + 9 * BIT] = 1'b1;
        exp_byte [d + 3 + HALF + 9 * BIT] = data;
      end else begin
        exp_ferr [d + 3 + HALF + 9 * BIT] = 1'b1;
      end
    end
    for (int i = 0; i < 10 * BIT; i++) begin
      rxd = bits[i / BIT];
      if (i == abort_off)   uart_en = 1'b0;
      if (i == rst_off)     rst_n   = 1'b0;
      if (i == rst_off + 3) rst_n   = 1'b1;
      tick();
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int d;
    int nv;

    rst_n   = 1'b0;
    uart_en = 1'b0;
    rxd     = 1'b1;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (3) tick();
    chk("reset_rx_data",   {24'd0, rx_data}, 32'h00);
    chk("reset_rx_valid",  {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_rx_busy",   {31'd0, rx_busy}, 32'd0);
    rst_n   = 1'b1;
    uart_en = 1'b1;
    idle(10);

    // Single frame: strobe 96 cycles after edge detect, i.e. 98 after drive.
    d = cyc;
    send_frame(8'h55, 1'b1, -1, -1);
    idle(10);
    chk("latency_55", last_valid_cyc - d, 32'd98);
    chk("data_55", {24'd0, rx_data}, 32'h55);

    // Three frames with no idle time between them.
    nv = n_valid;
    send_frame(8'hA3, 1'b1, -1, -1);
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    idle(10);
    chk("b2b_count", n_valid - nv, 32'd3);
    chk("b2b_last", {24'd0, rx_data}, 32'hFF);

    // Three-cycle low glitch: rejected at the start-bit sample.
    d = cyc;
    set_busy(d + 3, d + 2 + HALF);
    rxd = 1'b0;
    repeat (3) tick();
    idle(20);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(10);
    chk("data_3c", {24'd0, rx_data}, 32'h3C);

    // Bad stop bit, then line held low (break) for 50 cycles.
    send_frame(8'h81, 1'b0, -1, -1);
    repeat (50) tick();
    chk("ferr_count", n_ferr, 32'd1);
    chk("ferr_keeps_data", {24'd0, rx_data}, 32'h3C);
    idle(20);
    send_frame(8'h12, 1'b1, -1, -1);
    idle(10);
    chk("data_12", {24'd0, rx_data}, 32'h12);

    // Disable during data bit 4 (bit 4 occupies offsets 50..59).
    send_frame(8'h96, 1'b1, 55, -1);
    idle(10);
    chk("abort_busy", {31'd0, rx_busy}, 32'd0);
    uart_en = 1'b1;
    idle(10);
    send_frame(8'hC7, 1'b1, -1, -1);
    idle(10);
    chk("data_c7", {24'd0, rx_data}, 32'hC7);

    // Reset pulse during data bit 2 (offsets 30..39).
    send_frame(8'hFF, 1'b1, -1, 33);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    idle(10);
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(10);
    chk("data_5a", {24'd0, rx_data}, 32'h5A);
    chk("total_valid", n_valid, 32'd8);
    chk("total_ferr", n_ferr, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
